// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder in front of a word-addressed backing store standing in for physical memory.
// Read and write channels run independent FSMs, each with one transaction in flight and a fixed latency.
module axi_lite_mem_slave #(
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter logic [31:0] MEM_BASE      = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE      = 32'h0800_0000,
    parameter int unsigned STORE_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned IDX_W = $clog2(STORE_WORDS);
    localparam logic [7:0] RLAT_M1 = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WLAT_M1 = 8'(WRITE_LATENCY - 1);

    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

    // Offset subtraction keeps the upper-bound test free of 32-bit overflow near the top of the map.
    function automatic logic [1:0] checkAddr(input logic [31:0] a);
        logic [31:0] off;
        off = a - MEM_BASE;
        if (!(off < MEM_SIZE))   return RESP_DECERR;
        else if (a[1:0] != 2'b00) return RESP_SLVERR;
        else                      return RESP_OKAY;
    endfunction

    // The store is smaller than the decoded region, so region offsets alias modulo its size.
    function automatic logic [IDX_W-1:0] wordIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - MEM_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem_q [STORE_WORDS];

    logic [1:0]  rState_q, rState_d;
    logic [7:0]  rCnt_q, rCnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rAccess;
    logic [31:0] rAddrSel;
    logic [1:0]  rCheck;

    assign rAddrSel = (rState_q == R_IDLE) ? araddr : araddr_q;
    assign rCheck   = checkAddr(rAddrSel);

    always_comb begin
        rState_d  = rState_q;
        rCnt_d    = rCnt_q;
        araddr_d  = araddr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rAccess   = 1'b0;
        case (rState_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && arvalid) begin
                    arready_d = 1'b0;
                    araddr_d  = araddr;
                    if (READ_LATENCY == 1) begin
                        rAccess = 1'b1;
                    end else begin
                        rCnt_d   = RLAT_M1;
                        rState_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rCnt_d = rCnt_q - 8'd1;
                if (rCnt_q == 8'd1) rAccess = 1'b1;
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rState_d  = R_IDLE;
                end
            end
            default: rState_d = R_IDLE;
        endcase
        if (rAccess) begin
            rState_d = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = rCheck;
            rdata_d  = (rCheck == RESP_OKAY) ? mem_q[wordIdx(rAddrSel)] : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rState_q  <= R_IDLE;
            rCnt_q    <= 8'd0;
            araddr_q  <= 32'h0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
        end else begin
            rState_q  <= rState_d;
            rCnt_q    <= rCnt_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    logic [1:0]  wState_q, wState_d;
    logic [7:0]  wCnt_q, wCnt_d;
    logic        awFull_q, awFull_d, wFull_q, wFull_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wCommit, memWrEn;
    logic [31:0] wAddrSel, wDataSel;
    logic [3:0]  wStrbSel;
    logic [1:0]  wCheck;

    // A commit may coincide with the handshake that fills the last buffer, so take live inputs then.
    assign wAddrSel = awFull_q ? awaddr_q : awaddr;
    assign wDataSel = wFull_q  ? wdata_q  : wdata;
    assign wStrbSel = wFull_q  ? wstrb_q  : wstrb;
    assign wCheck   = checkAddr(wAddrSel);
    assign memWrEn  = wCommit && (wCheck == RESP_OKAY) && (wStrbSel != 4'b0000);

    always_comb begin
        wState_d = wState_q;
        wCnt_d   = wCnt_q;
        awFull_d = awFull_q;
        wFull_d  = wFull_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        wCommit  = 1'b0;
        case (wState_q)
            W_IDLE: begin
                if (awready_q && awvalid) begin
                    awFull_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (wready_q && wvalid) begin
                    wFull_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (awFull_d && wFull_d) begin
                    if (WRITE_LATENCY == 1) begin
                        wCommit = 1'b1;
                    end else begin
                        wCnt_d   = WLAT_M1;
                        wState_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                wCnt_d = wCnt_q - 8'd1;
                if (wCnt_q == 8'd1) wCommit = 1'b1;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    awFull_d = 1'b0;
                    wFull_d  = 1'b0;
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
        if (wCommit) begin
            wState_d = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = wCheck;
        end
        awready_d = !awFull_d && (wState_d != W_RESP);
        wready_d  = !wFull_d  && (wState_d != W_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wState_q  <= W_IDLE;
            wCnt_q    <= 8'd0;
            awFull_q  <= 1'b0;
            wFull_q   <= 1'b0;
            awaddr_q  <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            wState_q  <= wState_d;
            wCnt_q    <= wCnt_d;
            awFull_q  <= awFull_d;
            wFull_q   <= wFull_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Nonblocking update means a read sampled on the same edge still sees the old word.
    always_ff @(posedge clk) begin
        if (memWrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (wStrbSel[i]) mem_q[wordIdx(wAddrSel)][8*i +: 8] <= wDataSel[8*i +: 8];
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule
